// File: rtl/apb4_ip_mux.sv
// APB4 one-to-many mux: forwards an upstream APB4 transfer to the channel picked by sel_i,
// answers out-of-range selects with SLVERR and aborts stalled transfers after TIMEOUT wait cycles.
module apb4_ip_mux #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int SEL_W   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic [ADDR_W-1:0]        s_paddr_i,
    input  logic [2:0]               s_pprot_i,
    input  logic                     s_pwrite_i,
    input  logic [DATA_W-1:0]        s_pwdata_i,
    input  logic [DATA_W/8-1:0]      s_pstrb_i,
    input  logic                     s_psel_i,
    input  logic                     s_penable_i,
    output logic                     s_pready_o,
    output logic                     s_pslverr_o,
    output logic [DATA_W-1:0]        s_prdata_o,
    output logic [NUM_CH-1:0]        m_psel_o,
    output logic                     m_penable_o,
    output logic [ADDR_W-1:0]        m_paddr_o,
    output logic [2:0]               m_pprot_o,
    output logic                     m_pwrite_o,
    output logic [DATA_W-1:0]        m_pwdata_o,
    output logic [DATA_W/8-1:0]      m_pstrb_o,
    input  logic [NUM_CH-1:0]        m_pready_i,
    input  logic [NUM_CH-1:0]        m_pslverr_i,
    input  logic [NUM_CH*DATA_W-1:0] m_prdata_i,
    output logic [SEL_W-1:0]         cur_sel_o,
    output logic                     timeout_o
);

    // state  | meaning
    // IDLE   | no transfer; cur_sel follows sel_i while s_psel_i is low
    // SETUP  | APB setup phase forwarded to the selected channel
    // ACCESS | access phase; waiting for channel ready, local error or timeout
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [SEL_W:0]   NUM_CH_V = (SEL_W + 1)'(NUM_CH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;

    logic               valid;
    logic               in_access;
    logic               to_hit;
    logic               ch_ready;
    logic               ch_err;
    logic [DATA_W-1:0]  ch_rdata;

    assign m_paddr_o  = s_paddr_i;
    assign m_pprot_o  = s_pprot_i;
    assign m_pwrite_o = s_pwrite_i;
    assign m_pwdata_o = s_pwdata_i;
    assign m_pstrb_o  = s_pstrb_i;
    assign cur_sel_o  = cur_sel_q;

    assign valid     = {1'b0, cur_sel_q} < NUM_CH_V;
    assign in_access = rst_n_i && (state_q == S_ACCESS) && s_psel_i;
    assign to_hit    = (TIMEOUT != 0) && in_access && valid && !ch_ready && (cnt_q >= TO_VAL);
    assign timeout_o = to_hit;

    always_comb begin
        ch_ready = 1'b0;
        ch_err   = 1'b0;
        ch_rdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_sel_q == SEL_W'(k)) begin
                ch_ready = m_pready_i[k];
                ch_err   = m_pslverr_i[k];
                ch_rdata = m_prdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Reset gates every response combinationally so an interrupted transfer never completes.
    always_comb begin
        s_pready_o  = 1'b0;
        s_pslverr_o = 1'b0;
        s_prdata_o  = '0;
        if (in_access) begin
            if (!valid || to_hit) begin
                s_pready_o  = 1'b1;
                s_pslverr_o = 1'b1;
            end else begin
                s_pready_o  = ch_ready;
                s_pslverr_o = ch_err;
                s_prdata_o  = ch_rdata;
            end
        end
    end

    always_comb begin
        m_psel_o    = '0;
        m_penable_o = 1'b0;
        if (rst_n_i && valid && !to_hit && (state_q != S_IDLE)) begin
            for (int k = 0; k < NUM_CH; k++) begin
                m_psel_o[k] = (cur_sel_q == SEL_W'(k)) && s_psel_i;
            end
            m_penable_o = (state_q == S_ACCESS) && s_penable_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        case (state_q)
            S_IDLE: begin
                if (!s_psel_i) begin
                    cur_sel_d = sel_i;
                end else if (!s_penable_i) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = s_psel_i ? S_ACCESS : S_IDLE;
            end
            S_ACCESS: begin
                if (!s_psel_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (s_pready_o) begin
                    state_d   = S_SETUP;
                    cur_sel_d = sel_i;
                    cnt_d     = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cur_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
        end
    end

endmodule

// File: tb/tb_apb4_ip_mux.sv
// Directed bench for apb4_ip_mux: routing, wait states, sel change, timeout, invalid select, reset.
module tb_apb4_ip_mux;
    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int SEL_W   = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [SEL_W-1:0]         sel = '0;
    logic [ADDR_W-1:0]        s_paddr = '0;
    logic [2:0]               s_pprot = 3'b000;
    logic                     s_pwrite = 1'b0;
    logic [DATA_W-1:0]        s_pwdata = '0;
    logic [DATA_W/8-1:0]      s_pstrb = '1;
    logic                     s_psel = 1'b0;
    logic                     s_penable = 1'b0;
    logic                     s_pready, s_pslverr;
    logic [DATA_W-1:0]        s_prdata;
    logic [NUM_CH-1:0]        m_psel;
    logic                     m_penable;
    logic [ADDR_W-1:0]        m_paddr;
    logic [2:0]               m_pprot;
    logic                     m_pwrite;
    logic [DATA_W-1:0]        m_pwdata;
    logic [DATA_W/8-1:0]      m_pstrb;
    logic [NUM_CH-1:0]        m_pready = '0;
    logic [NUM_CH-1:0]        m_pslverr = '0;
    logic [NUM_CH*DATA_W-1:0] m_prdata = {32'h0BADC0DE, 32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF};
    logic [SEL_W-1:0]         cur_sel;
    logic                     timeout;

    int checks = 0;
    int errors = 0;

    apb4_ip_mux #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .SEL_W(SEL_W)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .sel_i(sel),
        .s_paddr_i(s_paddr), .s_pprot_i(s_pprot), .s_pwrite_i(s_pwrite),
        .s_pwdata_i(s_pwdata), .s_pstrb_i(s_pstrb),
        .s_psel_i(s_psel), .s_penable_i(s_penable),
        .s_pready_o(s_pready), .s_pslverr_o(s_pslverr), .s_prdata_o(s_prdata),
        .m_psel_o(m_psel), .m_penable_o(m_penable), .m_paddr_o(m_paddr),
        .m_pprot_o(m_pprot), .m_pwrite_o(m_pwrite), .m_pwdata_o(m_pwdata), .m_pstrb_o(m_pstrb),
        .m_pready_i(m_pready), .m_pslverr_i(m_pslverr), .m_prdata_i(m_prdata),
        .cur_sel_o(cur_sel), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One IDLE cycle with psel low to latch sel, then raise psel; returns in SETUP.
    task automatic start(input logic [SEL_W-1:0] s, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
        sel = s;
        s_psel = 1'b0;
        s_penable = 1'b0;
        tick();
        s_psel = 1'b1;
        s_pwrite = wr;
        s_paddr = addr;
        s_pwdata = wdata;
        tick();
    endtask

    task automatic go_access();
        tick();
        s_penable = 1'b1;
    endtask

    task automatic drop();
        s_psel = 1'b0;
        s_penable = 1'b0;
        m_pready = '0;
        m_pslverr = '0;
        tick();
        tick();
    endtask

    task automatic finish_xfer();
        tick();
        drop();
    endtask

    initial begin
        int cyc;
        bit got;

        // reset
        tick();
        @(negedge clk);
        chk("rst_psel", m_psel, 4'b0000);
        chk("rst_pready", s_pready, 1'b0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cur_sel", cur_sel, 4'd0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_penable", m_penable, 1'b0);

        // write on ch2, zero wait states
        start(4'd2, 1'b1, 32'h10, 32'hA5A5_0000);
        @(negedge clk);
        chk("wr_setup_psel", m_psel, 4'b0100);
        chk("wr_setup_penable", m_penable, 1'b0);
        chk("wr_setup_pready", s_pready, 1'b0);
        chk("wr_paddr", m_paddr, 32'h10);
        go_access();
        m_pready = 4'b0100;
        @(negedge clk);
        chk("wr_acc_psel", m_psel, 4'b0100);
        chk("wr_acc_penable", m_penable, 1'b1);
        chk("wr_pready", s_pready, 1'b1);
        chk("wr_pslverr", s_pslverr, 1'b0);
        chk("wr_pwdata", m_pwdata, 32'hA5A5_0000);
        finish_xfer();

        // read on ch1 with 3 wait states
        start(4'd1, 1'b0, 32'h20, 32'h0);
        cyc = 1;
        got = 1'b0;
        go_access();
        for (int i = 1; i <= 10; i++) begin
            m_pready = (i >= 4) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            cyc++;
            if (s_pready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("rd_completed", got, 1'b1);
        chk("rd_cycles", cyc, 5);
        chk("rd_prdata", s_prdata, 32'h1234_5678);
        chk("rd_pslverr", s_pslverr, 1'b0);
        finish_xfer();
        @(negedge clk);
        chk("idle_prdata", s_prdata, 32'h0);

        // sel change while ch1 waits
        start(4'd1, 1'b0, 32'h30, 32'h0);
        go_access();
        sel = 4'd3;
        tick();
        @(negedge clk);
        chk("selchg_hold", cur_sel, 4'd1);
        chk("selchg_psel", m_psel, 4'b0010);
        tick();
        m_pready = 4'b0010;
        @(negedge clk);
        chk("selchg_pready", s_pready, 1'b1);
        tick();
        @(negedge clk);
        chk("selchg_loaded", cur_sel, 4'd3);
        drop();
        start(4'd3, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        chk("selchg_next_psel", m_psel, 4'b1000);
        go_access();
        m_pready = 4'b1000;
        m_pslverr = 4'b1000;
        @(negedge clk);
        chk("ch3_pslverr", s_pslverr, 1'b1);
        chk("ch3_prdata", s_prdata, 32'h0BADC0DE);
        finish_xfer();

        // timeout on ch0
        start(4'd0, 1'b0, 32'h50, 32'h0);
        go_access();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("to_pready_%0d", i), s_pready, (i == 5));
            chk($sformatf("to_pulse_%0d", i), timeout, (i == 5));
            if (i < 5) tick();
        end
        chk("to_pslverr", s_pslverr, 1'b1);
        chk("to_prdata", s_prdata, 32'h0);
        chk("to_psel", m_psel, 4'b0000);
        chk("to_penable", m_penable, 1'b0);
        tick();
        @(negedge clk);
        chk("to_pulse_after", timeout, 1'b0);
        drop();

        // ch0 ready rises exactly on the timeout cycle
        start(4'd0, 1'b0, 32'h60, 32'h0);
        go_access();
        for (int i = 1; i <= 5; i++) begin
            m_pready = (i == 5) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (i < 5) tick();
        end
        chk("race_pready", s_pready, 1'b1);
        chk("race_pslverr", s_pslverr, 1'b0);
        chk("race_timeout", timeout, 1'b0);
        chk("race_prdata", s_prdata, 32'hDEAD_BEEF);
        finish_xfer();

        // out-of-range select
        start(4'd6, 1'b0, 32'h70, 32'h0);
        @(negedge clk);
        chk("inv_setup_psel", m_psel, 4'b0000);
        go_access();
        m_pready = 4'b1111;
        @(negedge clk);
        chk("inv_psel", m_psel, 4'b0000);
        chk("inv_pready", s_pready, 1'b1);
        chk("inv_pslverr", s_pslverr, 1'b1);
        chk("inv_prdata", s_prdata, 32'h0);
        finish_xfer();

        // psel dropped mid-access returns to IDLE without response
        start(4'd1, 1'b0, 32'h80, 32'h0);
        go_access();
        s_psel = 1'b0;
        s_penable = 1'b0;
        m_pready = 4'b0010;
        @(negedge clk);
        chk("abort_pready", s_pready, 1'b0);
        tick();
        s_psel = 1'b1;
        @(negedge clk);
        chk("abort_idle_psel", m_psel, 4'b0000);
        drop();

        // reset during ACCESS
        start(4'd2, 1'b1, 32'h90, 32'h1111_2222);
        go_access();
        m_pready = 4'b0100;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstacc_pready", s_pready, 1'b0);
        chk("rstacc_psel", m_psel, 4'b0000);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstacc_cur_sel", cur_sel, 4'd0);
        chk("rstacc_after_pready", s_pready, 1'b0);
        chk("rstacc_after_psel", m_psel, 4'b0000);
        chk("rstacc_after_penable", m_penable, 1'b0);
        chk("rstacc_after_timeout", timeout, 1'b0);
        drop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
